// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control FSM: sequences IF/ID/EX/MEM/WB over a shared memory with a
// variable- or fixed-latency handshake, a taken-branch state, a halt/trap state and counters.
module multicycle_ctrl_fsm #(
  parameter int unsigned FIXED_MEM_LAT = 0,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       opcode_i,
  input  logic             bcond_i,
  input  logic             mem_ready_i,
  input  logic             halt_req_i,
  output logic             ir_write_o,
  output logic             i_or_d_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             mem_to_reg_o,
  output logic             alu_src_a_o,
  output logic             reg_write_o,
  output logic             pc_write_o,
  output logic             pc_write_not_cond_o,
  output logic             pc_src_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic             is_ecall_o,
  output logic             halted_o,
  output logic             illegal_inst_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic [CNT_W-1:0] instret_o
);

  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIArith = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpEcall  = 7'b1110011;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBFour = 2'b01;
  localparam logic [1:0] SrcBImm  = 2'b10;
  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluFunct = 2'b01;
  localparam logic [1:0] AluBr    = 2'b10;

  localparam int unsigned WaitW    = (FIXED_MEM_LAT > 2) ? $clog2(FIXED_MEM_LAT) : 1;
  localparam int unsigned LastWait = (FIXED_MEM_LAT > 0) ? FIXED_MEM_LAT - 1 : 0;

  typedef enum logic [2:0] {
    StIf, StId, StEx, StMem, StWb, StBrTaken, StHalt
  } state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               mem_done;
  logic               is_load;
  logic               retire;

  assign is_load = (opcode_i == OpLoad);

  always_comb begin
    if (FIXED_MEM_LAT == 0) begin
      mem_done = mem_ready_i;
    end else begin
      mem_done = (wait_q == WaitW'(LastWait));
    end
  end

  always_comb begin
    state_d             = state_q;
    illegal_d           = illegal_q;
    ir_write_o          = 1'b0;
    i_or_d_o            = 1'b0;
    mem_read_o          = 1'b0;
    mem_write_o         = 1'b0;
    mem_to_reg_o        = 1'b0;
    alu_src_a_o         = 1'b0;
    reg_write_o         = 1'b0;
    pc_write_o          = 1'b0;
    pc_write_not_cond_o = 1'b0;
    pc_src_o            = 1'b0;
    alu_src_b_o         = SrcBFour;
    alu_op_o            = AluAdd;
    is_ecall_o          = 1'b0;
    halted_o            = 1'b0;

    unique case (state_q)
      StIf: begin
        mem_read_o = 1'b1;
        if (mem_done) begin
          ir_write_o = 1'b1;
          state_d    = StId;
        end
      end
      StId: begin
        // ALU computes PC+4 here so ALUOut holds the link/fall-through address
        case (opcode_i)
          OpEcall: begin
            is_ecall_o = 1'b1;
            if (halt_req_i) begin
              state_d = StHalt;
            end else begin
              pc_write_o = 1'b1;
              state_d    = StIf;
            end
          end
          OpRType, OpIArith, OpLoad, OpStore, OpBranch, OpJal, OpJalr: state_d = StEx;
          default: begin
            illegal_d = 1'b1;
            state_d   = StHalt;
          end
        endcase
      end
      StEx: begin
        state_d = StIf;
        case (opcode_i)
          OpRType: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SrcBRs2;
            alu_op_o    = AluFunct;
            state_d     = StWb;
          end
          OpIArith: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SrcBImm;
            alu_op_o    = AluFunct;
            state_d     = StWb;
          end
          OpLoad, OpStore: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SrcBImm;
            state_d     = StMem;
          end
          OpBranch: begin
            alu_src_a_o         = 1'b1;
            alu_src_b_o         = SrcBRs2;
            alu_op_o            = AluBr;
            pc_write_not_cond_o = 1'b1;
            pc_src_o            = 1'b1;
            state_d             = bcond_i ? StBrTaken : StIf;
          end
          OpJal, OpJalr: begin
            reg_write_o = 1'b1;
            alu_src_a_o = (opcode_i == OpJalr);
            alu_src_b_o = SrcBImm;
            pc_write_o  = 1'b1;
          end
          default: ;
        endcase
      end
      StMem: begin
        i_or_d_o    = 1'b1;
        mem_read_o  = is_load;
        mem_write_o = !is_load;
        if (mem_done) begin
          if (is_load) begin
            state_d = StWb;
          end else begin
            pc_write_o = 1'b1;
            state_d    = StIf;
          end
        end
      end
      StWb: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = is_load;
        pc_write_o   = 1'b1;
        state_d      = StIf;
      end
      StBrTaken: begin
        alu_src_b_o = SrcBImm;
        pc_write_o  = 1'b1;
        state_d     = StIf;
      end
      StHalt: halted_o = 1'b1;
      default: state_d = StIf;
    endcase

    // No strobe may reach the datapath while reset is held
    if (rst_i) begin
      ir_write_o          = 1'b0;
      i_or_d_o            = 1'b0;
      mem_read_o          = 1'b0;
      mem_write_o         = 1'b0;
      mem_to_reg_o        = 1'b0;
      alu_src_a_o         = 1'b0;
      reg_write_o         = 1'b0;
      pc_write_o          = 1'b0;
      pc_write_not_cond_o = 1'b0;
      pc_src_o            = 1'b0;
      alu_src_b_o         = 2'b00;
      alu_op_o            = 2'b00;
      is_ecall_o          = 1'b0;
      halted_o            = 1'b0;
    end
  end

  // Wait counter runs only while an access is still pending; any state change clears it
  always_comb begin
    wait_d = '0;
    if ((FIXED_MEM_LAT != 0) && (state_q == StIf || state_q == StMem) &&
        (state_d == state_q) && !mem_done) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  always_comb begin
    retire = ((state_d == StIf) && (state_q != StIf)) ||
             ((state_q == StId) && (state_d == StHalt) && (opcode_i == OpEcall));
    cycle_d   = (state_q != StHalt) ? cycle_q + CNT_W'(1) : cycle_q;
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIf;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign illegal_inst_o = illegal_q;
  assign cycle_count_o  = cycle_q;
  assign instret_o      = instret_q;

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Parametrised multicycle RV32I control unit. It sequences fetch, decode, execute, memory and writeback for the shared-memory multicycle datapath. Successor to the fixed-latency controller, with these additions:
- variable- or fixed-latency memory handshake
- explicit BRANCH-taken and HALT states
- illegal-opcode trap
- cycle and retired-instruction counters

It sits beside the datapath and drives every mux and strobe from a registered state.

## Interface
- FIXED_MEM_LAT, 0: 0 = memory completion taken from `mem_ready`; N>0 = `mem_ready` ignored, access completes on the Nth cycle in IF/MEM.
- CNT_W, 32: width of `cycle_count` and `instret`.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- opcode  in  7  IR[6:0], valid from ID onward; ignored in IF.
- bcond  in  1  branch condition from ALU, valid in EX.
- mem_ready  in  1  memory completion (used only when FIXED_MEM_LAT=0).
- halt_req  in  1  ecall halt condition (x17==10), valid in ID.
- ir_write, i_or_d, mem_read, mem_write, mem_to_reg, alu_src_a, reg_write, pc_write, pc_write_not_cond, pc_src  out  1 each  datapath strobes/selects.
- alu_src_b  out  2  00 = rs2, 01 = const 4, 10 = imm.
- alu_op  out  2  00 = ADD, 01 = FUNCT, 10 = BRANCH compare.
- is_ecall  out  1  ecall decoded in ID.
- halted  out  1  FSM in HALT.
- illegal_inst  out  1  HALT was entered via an unknown opcode (sticky until reset).
- cycle_count  out  CNT_W  cycles since reset, excluding HALT.
- instret  out  CNT_W  retired instructions.

## Operation
- States: IF, ID, EX, MEM, WB, BR_TAKEN, HALT.
- Outputs are decoded combinationally from the registered state, opcode, bcond and mem_done.
- Defaults: every strobe 0, alu_src_a=0, alu_src_b=01, alu_op=00.
- mem_done:
  - FIXED_MEM_LAT=0: mem_done = mem_ready.
  - FIXED_MEM_LAT>0: wait counter clears on entry to IF/MEM; mem_done is true when the counter equals FIXED_MEM_LAT-1.
- IF: mem_read=1, i_or_d=0, held for the whole wait. ir_write=1 only in the mem_done cycle, which also moves to ID; otherwise stay in IF.
- ID: a=PC, b=4, ADD (ALUOut latches PC+4).
  - ECALL (1110011): is_ecall=1.
    - halt_req=1: go to HALT, counts as retired.
    - halt_req=0: pc_write=1, pc_src=0, go to IF.
  - Known opcodes: go to EX.
  - Unknown opcode: set illegal_inst, go to HALT; not retired.
- EX, by opcode:
  - R-type (0110011): a=rs1, b=rs2, FUNCT, go to WB.
  - I-arith (0010011): a=rs1, b=imm, FUNCT, go to WB.
  - LOAD (0000011) / STORE (0100011): a=rs1, b=imm, ADD, go to MEM.
  - BRANCH (1100011): a=rs1, b=rs2, BRANCH compare, pc_write_not_cond=1, pc_src=1 (PC←ALUOut=PC+4 if !bcond). bcond=1 goes to BR_TAKEN; bcond=0 goes to IF.
  - JAL (1101111): reg_write=1, mem_to_reg=0 (rd←ALUOut=PC+4); a=PC, b=imm, ADD, pc_write=1, pc_src=0; go to IF.
  - JALR (1100111): same as JAL except a=rs1.
- BR_TAKEN: a=PC, b=imm, ADD, pc_write=1, pc_src=0, go to IF.
- MEM: i_or_d=1; mem_read=1 for LOAD, mem_write=1 for STORE, held until mem_done.
  - LOAD on mem_done: go to WB.
  - STORE on mem_done: additionally a=PC, b=4, ADD, pc_write=1, go to IF.
- WB: reg_write=1, mem_to_reg=1 for LOAD else 0; a=PC, b=4, ADD, pc_write=1, pc_src=0; go to IF.
- HALT: absorbing until reset. halted=1, all strobes 0.
- instret increments on every transition into IF from ID/EX/MEM/WB/BR_TAKEN, and on ecall entry to HALT.
- cycle_count increments every non-HALT cycle.
- Both counters wrap modulo 2^CNT_W.

## Timing
- Reset asserted, asynchronously: state=IF, wait counter=0, counters=0, halted=0, illegal_inst=0. All outputs forced 0 while reset is high, including mem_read.
- First cycle after release: IF outputs.
- Reset mid-access aborts the access; no write strobe may be asserted during reset.
- Latency with single-cycle memory (FIXED_MEM_LAT=1 or mem_ready tied 1):
  - R/I: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - Branch not taken: 3 cycles; taken: 4 cycles.
  - JAL/JALR: 3 cycles.
  - Non-halting ECALL: 2 cycles.
- Each memory wait cycle adds one cycle in IF or MEM.
- mem_ready asserted in the first IF/MEM cycle completes that cycle.
- mem_ready high outside IF/MEM is ignored.
- pc_write and pc_write_not_cond are never both 1.
- reg_write and mem_write are never both 1.

## Test plan
- ADD then LW then SW, FIXED_MEM_LAT=1 → state sequences IF,ID,EX,WB / IF,ID,EX,MEM,WB / IF,ID,EX,MEM; instret=3 after 13 cycles.
- FIXED_MEM_LAT=0, mem_ready low 3 cycles in IF → mem_read high 4 cycles, ir_write high only on the 4th cycle, then ID.
- BEQ with bcond=0 → pc_write_not_cond=1, pc_src=1 in EX, next IF. BEQ with bcond=1 → BR_TAKEN with pc_write=1, alu_src_b=10.
- ECALL: halt_req=0 → pc_write in ID, back to IF. halt_req=1 → halted=1, counters frozen, instret incremented.
- Opcode 7'b1111111 → HALT with illegal_inst=1, instret unchanged.
- Reset pulsed mid-MEM STORE → mem_write drops in the same cycle, counters 0, IF after release. With CNT_W=4, 16 cycles → cycle_count wraps to 0.
